// File: rtl/avalon_mm_block_mover.sv
// rtl/avalon_mm_block_mover.sv - Avalon-MM master that copies or fills a block of 32-bit words
module avalon_mm_block_mover #(
  parameter int ADDR_W       = 10,
  parameter int LEN_W        = 11,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [31:0]       fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  input  logic              waitrequest
);

  localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [3:0]          be_q, be_d;

  // State, counters and every bus output are registered; reset abandons any block silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
    end
  end

  // Next-state logic; bus outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = length;
          if (length == '0) begin
            done_d = 1'b1;
          end else if (mode) begin
            state_d = WR_REQ;
            addr_d  = dst_addr;
            wdata_d = fill_value;
          end else begin
            state_d = RD_REQ;
            addr_d  = src_addr;
          end
        end
      end
      RD_REQ: begin
        if (!waitrequest) begin
          state_d = RD_WAIT;
          lat_d   = LAT_W'(READ_LATENCY);
        end
      end
      RD_WAIT: begin
        if (lat_q == LAT_W'(1)) begin
          wdata_d = readdata;
          state_d = WR_REQ;
          addr_d  = dst_q;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      WR_REQ: begin
        if (!waitrequest) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Addresses wrap modulo 2^ADDR_W by plain truncation.
            src_d = src_q + ADDR_W'(1);
            dst_d = dst_q + ADDR_W'(1);
            if (mode_q) begin
              addr_d = dst_q + ADDR_W'(1);
            end else begin
              state_d = RD_REQ;
              addr_d  = src_q + ADDR_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    cs_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    wr_d   = (state_d == WR_REQ);
    be_d   = cs_d ? 4'hF : 4'h0;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign address    = addr_q;
  assign byteenable = be_q;
  assign chipselect = cs_q;
  assign write      = wr_q;
  assign writedata  = wdata_q;

endmodule

// File: tb/tb_avalon_mm_block_mover.sv
// tb/tb_avalon_mm_block_mover.sv - directed self-checking bench for avalon_mm_block_mover
module tb_avalon_mm_block_mover;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [9:0]  src_addr = '0;
  logic [9:0]  dst_addr = '0;
  logic [10:0] length = '0;
  logic [31:0] fill_value = '0;
  logic        busy, done, chipselect, write, waitrequest;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] rd_data;

  int checks = 0;
  int fails = 0;

  logic [31:0] mem [0:1023];
  logic [9:0]  wr_log[$];
  int          stall_cycles = 0;
  int          wait_cnt = 0;
  int          cs_cnt = 0, wr_cnt = 0, rd_cnt = 0, stall_cnt = 0, done_cnt = 0;
  int          stab_err = 0, both_err = 0;
  logic        prev_stall = 1'b0;
  logic [9:0]  s_addr;
  logic        s_wr;
  logic [31:0] s_wd;
  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;

  avalon_mm_block_mover dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
    .busy(busy), .done(done), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata),
    .readdata(rd_data), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  assign waitrequest = chipselect && (wait_cnt < stall_cycles);

  // Memory slave with one cycle of read latency plus bus monitors.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] = poke_data;
    if (chipselect) cs_cnt++;
    if (done) done_cnt++;
    if (busy && done) both_err++;
    if (prev_stall && (address !== s_addr || write !== s_wr || writedata !== s_wd)) stab_err++;
    prev_stall = chipselect && waitrequest;
    s_addr = address;
    s_wr   = write;
    s_wd   = writedata;
    if (chipselect && waitrequest) begin
      stall_cnt++;
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      if (chipselect) begin
        if (write) begin
          mem[address] = writedata;
          wr_cnt++;
          wr_log.push_back(address);
        end else begin
          rd_cnt++;
          rd_data <= mem[address];
        end
      end
    end
  end

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic run_cmd(input logic m, input logic [9:0] s, input logic [9:0] d,
                         input logic [10:0] len, input logic [31:0] fv, input int inject_at,
                         output int cycles, output int done_at, output bit timed_out);
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len; fill_value = fv;
    @(negedge clk);
    start = 1'b0;
    cycles = 0; done_at = -1; timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        timed_out = 1'b0;
        done_at = i;
        break;
      end
      if (busy) cycles++;
      if (i == inject_at) begin
        start = 1'b1; mode = 1'b1; src_addr = 10'h300; dst_addr = 10'h010;
        length = 11'd2; fill_value = 32'h5555_5555;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, chipselect, write, address, byteenable, writedata} !== 50'd0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%b done=%b cs=%b wr=%b addr=%h be=%h wd=%h want all 0",
               busy, done, chipselect, write, address, byteenable, writedata);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_copy;
    int cyc, dat, cs0, wr0;
    bit to;
    for (int i = 0; i < 4; i++) poke(10'h010 + 10'(i), 32'hA0A0_0000 + 32'(i));
    stall_cycles = 0;
    cs0 = cs_cnt; wr0 = wr_cnt;
    run_cmd(1'b0, 10'h010, 10'h100, 11'd4, 32'h0, -1, cyc, dat, to);
    checks++;
    if (to || dat != 12) begin fails++; $display("FAIL copy_done_at got %0d (timeout=%0d) want 12", dat, to); end
    checks++;
    if (cyc != 12) begin fails++; $display("FAIL copy_busy_cycles got %0d want 12", cyc); end
    checks++;
    if (cs_cnt - cs0 != 8 || wr_cnt - wr0 != 4) begin
      fails++; $display("FAIL copy_bus_cycles got cs=%0d wr=%0d want 8 4", cs_cnt - cs0, wr_cnt - wr0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[10'h100 + 10'(i)] !== 32'hA0A0_0000 + 32'(i)) begin
        fails++; $display("FAIL copy_data[%0d] got %h want %h", i, mem[10'h100 + 10'(i)], 32'hA0A0_0000 + 32'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL copy_done_width got done=%b want 0", done); end
  endtask

  task automatic test_fill_wrap;
    int cyc, dat, n;
    bit to;
    logic [9:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    stall_cycles = 0;
    n = wr_log.size();
    run_cmd(1'b1, 10'h000, 10'h3FE, 11'd4, 32'hDEAD_BEEF, -1, cyc, dat, to);
    checks++;
    if (to || dat != 4 || cyc != 4) begin
      fails++; $display("FAIL fill_cycles got done_at=%0d busy=%0d want 4 4", dat, cyc);
    end
    checks++;
    if (wr_log.size() - n != 4) begin
      fails++; $display("FAIL fill_write_count got %0d want 4", wr_log.size() - n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_log[n + i] !== exp_a[i] || mem[exp_a[i]] !== 32'hDEAD_BEEF) begin
          fails++; $display("FAIL fill_write[%0d] got addr=%h data=%h want %h DEADBEEF", i, wr_log[n + i], mem[exp_a[i]], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_zero_length;
    int cyc, dat, cs0;
    bit to;
    cs0 = cs_cnt;
    run_cmd(1'b0, 10'h010, 10'h200, 11'd0, 32'h0, -1, cyc, dat, to);
    checks++;
    if (to || dat != 0 || cyc != 0) begin
      fails++; $display("FAIL zero_len_done got done_at=%0d busy=%0d want 0 0", dat, cyc);
    end
    @(negedge clk);
    checks++;
    if (cs_cnt != cs0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_len_bus got cs=%0d done=%b busy=%b want 0 0 0", cs_cnt - cs0, done, busy);
    end
  endtask

  task automatic test_stall;
    int cyc, dat, st0, se0;
    bit to;
    poke(10'h040, 32'h1357_9BDF);
    poke(10'h041, 32'h2468_ACE0);
    stall_cycles = 3;
    st0 = stall_cnt; se0 = stab_err;
    run_cmd(1'b0, 10'h040, 10'h140, 11'd2, 32'h0, -1, cyc, dat, to);
    stall_cycles = 0;
    checks++;
    if (to || dat != 18 || cyc != 18) begin
      fails++; $display("FAIL stall_cycles got done_at=%0d busy=%0d want 18 18", dat, cyc);
    end
    checks++;
    if (stall_cnt - st0 != 12 || stab_err != se0) begin
      fails++; $display("FAIL stall_stable got stalls=%0d unstable=%0d want 12 0", stall_cnt - st0, stab_err - se0);
    end
    checks++;
    if (mem[10'h140] !== 32'h1357_9BDF || mem[10'h141] !== 32'h2468_ACE0) begin
      fails++; $display("FAIL stall_data got %h %h want 13579bdf 2468ace0", mem[10'h140], mem[10'h141]);
    end
  endtask

  task automatic test_ignore_start;
    int cyc, dat, wr0;
    bit to;
    stall_cycles = 0;
    wr0 = wr_cnt;
    run_cmd(1'b0, 10'h010, 10'h200, 11'd4, 32'h0, 3, cyc, dat, to);
    checks++;
    if (to || dat != 12 || wr_cnt - wr0 != 4) begin
      fails++; $display("FAIL ignore_start_timing got done_at=%0d writes=%0d want 12 4", dat, wr_cnt - wr0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[10'h200 + 10'(i)] !== 32'hA0A0_0000 + 32'(i)) begin
        fails++; $display("FAIL ignore_start_data[%0d] got %h want %h", i, mem[10'h200 + 10'(i)], 32'hA0A0_0000 + 32'(i));
      end
    end
    checks++;
    if (mem[10'h010] !== 32'hA0A0_0000) begin
      fails++; $display("FAIL ignore_start_src got %h want a0a00000", mem[10'h010]);
    end
  endtask

  task automatic test_overlap;
    int cyc, dat;
    bit to;
    poke(10'h020, 32'h1234_5678);
    poke(10'h021, 32'h1);
    poke(10'h022, 32'h2);
    poke(10'h023, 32'h3);
    run_cmd(1'b0, 10'h020, 10'h021, 11'd3, 32'h0, -1, cyc, dat, to);
    checks++;
    if (to || mem[10'h021] !== 32'h1234_5678 || mem[10'h022] !== 32'h1234_5678 || mem[10'h023] !== 32'h1234_5678) begin
      fails++; $display("FAIL overlap_propagate got %h %h %h want 12345678 x3", mem[10'h021], mem[10'h022], mem[10'h023]);
    end
  endtask

  task automatic test_reset_mid;
    int rd0, d0, cyc, dat;
    bit hit, to;
    for (int i = 0; i < 4; i++) poke(10'h050 + 10'(i), 32'hC0C0_0000 + 32'(i));
    for (int i = 0; i < 4; i++) poke(10'h150 + 10'(i), 32'h0);
    stall_cycles = 0;
    rd0 = rd_cnt;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = 10'h050; dst_addr = 10'h150; length = 11'd4;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd_cnt - rd0 == 2 && busy && !chipselect) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin fails++; $display("FAIL reset_mid_reach got 0 want 1 (second RD_WAIT not seen)"); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, chipselect, write, address, byteenable, writedata} !== 50'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b cs=%b wr=%b addr=%h be=%h wd=%h want all 0",
               busy, done, chipselect, write, address, byteenable, writedata);
    end
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0 || mem[10'h151] !== 32'h0) begin
      fails++; $display("FAIL reset_mid_abandon got dones=%0d busy=%b mem151=%h want 0 0 0", done_cnt - d0, busy, mem[10'h151]);
    end
    run_cmd(1'b0, 10'h050, 10'h150, 11'd4, 32'h0, -1, cyc, dat, to);
    checks++;
    if (to || dat != 12) begin fails++; $display("FAIL reset_mid_rerun_timing got %0d want 12", dat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[10'h150 + 10'(i)] !== 32'hC0C0_0000 + 32'(i)) begin
        fails++; $display("FAIL reset_mid_rerun_data[%0d] got %h want %h", i, mem[10'h150 + 10'(i)], 32'hC0C0_0000 + 32'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill_wrap();
    test_zero_length();
    test_stall();
    test_ignore_start();
    test_overlap();
    test_reset_mid();
    checks++;
    if (both_err != 0) begin fails++; $display("FAIL busy_done_overlap got %0d cycles want 0", both_err); end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
